// File: rtl/spi_reg_peripheral_if.sv
// spi_reg_peripheral_if: SPI pin bundle between an external controller and the register target
interface spi_reg_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;
  modport master(output sclk, copi, ncs, input cipo);
  modport slave(input sclk, copi, ncs, output cipo);
endinterface

// File: rtl/spi_reg_peripheral.sv
// spi_reg_peripheral: mode-0 SPI write target for five PWM control registers; SPI_READBACK_EN adds register reads on cipo
module spi_reg_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_reg_peripheral_if.slave  spi,
  output logic [7:0]           en_reg_out_7_0,
  output logic [7:0]           en_reg_out_15_8,
  output logic [7:0]           en_reg_pwm_7_0,
  output logic [7:0]           en_reg_pwm_15_8,
  output logic [7:0]           pwm_duty_cycle
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  logic [SYNC_STAGES:0] sclk_q;
  logic [SYNC_STAGES:0] ncs_q;
  logic [SYNC_STAGES-1:0] copi_q;
  logic [1:0] state;
  logic [4:0] cnt;
  logic [15:0] sr;
  logic [7:0] regs [5];
  logic sclk_rise;
  logic ncs_rise;
  logic ncs_s;
  logic copi_s;
  logic commit_ok;
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign ncs_rise = ncs_q[SYNC_STAGES-1] & ~ncs_q[SYNC_STAGES];
  assign ncs_s = ncs_q[SYNC_STAGES-1];
  assign copi_s = copi_q[SYNC_STAGES-1];
  assign commit_ok = state == COMMIT && cnt == 5'd16 && sr[15] && int'(sr[14:8]) <= MAX_ADDR;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q <= '0;
      ncs_q <= '1;
      copi_q <= '0;
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], spi.sclk};
      ncs_q <= {ncs_q[SYNC_STAGES-1:0], spi.ncs};
      copi_q <= {copi_q[SYNC_STAGES-2:0], spi.copi};
      if (state == IDLE && !ncs_s) begin
        state <= SHIFT;
        cnt <= '0;
        sr <= '0;
      end else if (state == SHIFT && ncs_rise) begin
        state <= COMMIT;
      end else if (state == SHIFT && sclk_rise) begin
        sr <= {sr[14:0], copi_s};
        cnt <= cnt == 5'd17 ? cnt : cnt + 5'd1;
      end else if (state == COMMIT) begin
        state <= IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) if (commit_ok && sr[14:8] == 7'(i)) regs[i] <= sr[7:0];
    end
  end
  assign en_reg_out_7_0 = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0 = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle = regs[4];
`ifdef SPI_READBACK_EN
  logic sclk_fall;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] tx;
  logic rd;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  assign rd_addr = {sr[5:0], copi_s};
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 5; i++) if (i <= MAX_ADDR && rd_addr == 7'(i)) rd_data = regs[i];
  end
  // first data bit is already on cipo before the 9th rise, so shifting starts at the 9th fall
  always_ff @(posedge clk) begin
    if (!rst_n || state != SHIFT || ncs_rise) begin
      rd <= 1'b0;
      tx <= '0;
    end else if (sclk_rise && cnt == 5'd7 && !sr[6]) begin
      rd <= 1'b1;
      tx <= rd_data;
    end else if (sclk_fall && rd && cnt >= 5'd9) begin
      tx <= {tx[6:0], 1'b0};
    end
  end
  assign spi.cipo = rd & tx[7];
`else
  assign spi.cipo = 1'b0;
`endif
endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb_spi_reg_peripheral: table-driven SPI frame checks of the register target plus reset and readback sequences
module tb_spi_reg_peripheral;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] r0, r1, r2, r3, r4;
  logic [39:0] regs_now;
  logic [16:0] rx;
  logic [39:0] pre;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [16:0] frame;
    int n;
    logic [39:0] exp;
    string name;
  } vec_t;
  vec_t v[10];
  always #5 clk = ~clk;
  spi_reg_peripheral_if bus();
  spi_reg_peripheral #(.SYNC_STAGES(S), .MAX_ADDR(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi(bus),
    .en_reg_out_7_0(r0),
    .en_reg_out_15_8(r1),
    .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3),
    .pwm_duty_cycle(r4)
  );
  assign regs_now = {r4, r3, r2, r1, r0};
  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic frame(input logic [16:0] f, input int n, output logic [16:0] got);
    got = '0;
    bus.ncs = 1'b0;
    clks(4);
    for (int i = n - 1; i >= 0; i--) begin
      bus.copi = f[i];
      clks(4);
      got = {got[15:0], bus.cipo};
      bus.sclk = 1'b1;
      clks(4);
      bus.sclk = 1'b0;
    end
    clks(4);
    bus.ncs = 1'b1;
  endtask
  initial begin
    v[0] = '{17'h080A5, 16, 40'h00_00_00_00_A5, "wr_addr0"};
    v[1] = '{17'h08480, 16, 40'h80_00_00_00_A5, "wr_addr4"};
    v[2] = '{17'h082FF, 16, 40'h80_00_FF_00_A5, "wr_addr2"};
    v[3] = '{17'h08555, 16, 40'h80_00_FF_00_A5, "addr5_drop"};
    v[4] = '{17'h0FF55, 16, 40'h80_00_FF_00_A5, "addr7f_drop"};
    v[5] = '{17'h040D5, 15, 40'h80_00_FF_00_A5, "short15_drop"};
    v[6] = '{17'h10354, 17, 40'h80_00_FF_00_A5, "long17_drop"};
    v[7] = '{17'h0813C, 16, 40'h80_00_FF_3C_A5, "wr_addr1"};
    v[8] = '{17'h00311, 16, 40'h80_00_FF_3C_A5, "read_nowrite"};
    v[9] = '{17'h08396, 16, 40'h80_96_FF_3C_A5, "wr_addr3"};
    rst_n = 1'b0;
    bus.ncs = 1'b1;
    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    clks(3);
    check("reset_regs", regs_now, 40'h0);
    check("reset_cipo", {39'h0, bus.cipo}, 40'h0);
    rst_n = 1'b1;
    clks(4);
    pre = 40'h0;
    for (int k = 0; k < 10; k++) begin
      frame(v[k].frame, v[k].n, rx);
      clks(S + 1);
      check({v[k].name, "_early"}, regs_now, pre);
      clks(1);
      check(v[k].name, regs_now, v[k].exp);
      check({v[k].name, "_cipo"}, {39'h0, bus.cipo}, 40'h0);
      pre = v[k].exp;
      clks(4);
    end
    frame(17'h00300, 16, rx);
`ifdef SPI_READBACK_EN
    check("read_addr3", {24'h0, rx[15:0]}, 40'h96);
`else
    check("read_addr3", {24'h0, rx[15:0]}, 40'h0);
`endif
    clks(S + 6);
    check("read_addr3_regs", regs_now, pre);
    check("read_cipo_idle", {39'h0, bus.cipo}, 40'h0);
    frame(17'h00900, 16, rx);
    check("read_addr9", {24'h0, rx[15:0]}, 40'h0);
    clks(S + 6);
    check("read_addr9_regs", regs_now, pre);
    bus.ncs = 1'b0;
    clks(4);
    for (int i = 15; i >= 6; i--) begin
      bus.copi = v[1].frame[i];
      clks(4);
      bus.sclk = 1'b1;
      clks(4);
      bus.sclk = 1'b0;
    end
    rst_n = 1'b0;
    clks(2);
    rst_n = 1'b1;
    clks(4);
    bus.ncs = 1'b1;
    clks(S + 6);
    check("midframe_reset", regs_now, 40'h0);
    check("midframe_cipo", {39'h0, bus.cipo}, 40'h0);
    frame(17'h0847E, 16, rx);
    clks(S + 2);
    check("after_reset_wr", regs_now, 40'h7E_00_00_00_00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
